// File: rtl/nvram_sequencer.sv
// NOVRAM store/recall sequencer: copies the working RAM to the shadow array on STORE,
// and the shadow array back to RAM on RECALL. It arbitrates CPU strobes against host
// save/load requests and holds NV_BUSY for the whole copy plus the settle time.
module nvram_sequencer #(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 4,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          STORE,
  input  logic          RECALLn,
  input  logic          HOST_STORE_REQ,
  input  logic          HOST_RECALL_REQ,
  output logic          HOST_ACK,
  output logic          NV_BUSY,
  output logic [AW-1:0] NV_RADDR,
  output logic [AW-1:0] NV_WADDR,
  input  logic [DW-1:0] RAM_RDATA,
  input  logic [DW-1:0] SHADOW_RDATA,
  output logic          RAM_WE,
  output logic          SHADOW_WE,
  output logic [DW-1:0] WDATA
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned HW    = 16;

  typedef enum logic [1:0] {IDLE, COPY, HOLD} state_t;

  state_t          state, state_n;
  logic            store_d, recalln_d;
  logic            pend_st, pend_st_n, pend_rc, pend_rc_n;
  logic            dir_rc, dir_rc_n;
  logic            from_host, from_host_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic [HW-1:0]   hold_cnt, hold_cnt_n;
  logic [AW-1:0]   raddr_n, waddr_n;
  logic            ram_we_n, shadow_we_n, ack_n;
  logic            st_edge, rc_edge, eff_st, eff_rc, launch;

  // Next-state, pending-flag and registered-output logic.
  always_comb begin
    st_edge     = STORE & ~store_d;
    rc_edge     = ~RECALLn & recalln_d;
    // A store strobe seen while recall is asserted is dropped.
    eff_st      = pend_st | (st_edge & RECALLn);
    eff_rc      = pend_rc | rc_edge;
    cnt_inc     = cnt + CW'(1);
    state_n     = state;
    pend_st_n   = eff_st;
    pend_rc_n   = eff_rc;
    dir_rc_n    = dir_rc;
    from_host_n = from_host;
    cnt_n       = cnt;
    hold_cnt_n  = hold_cnt;
    raddr_n     = '0;
    waddr_n     = '0;
    ram_we_n    = 1'b0;
    shadow_we_n = 1'b0;
    ack_n       = 1'b0;
    launch      = 1'b1;
    case (state)
      IDLE: begin
        if (eff_rc) begin
          dir_rc_n    = 1'b1;
          from_host_n = 1'b0;
          pend_rc_n   = 1'b0;
        end else if (eff_st) begin
          dir_rc_n    = 1'b0;
          from_host_n = 1'b0;
          pend_st_n   = 1'b0;
        end else if (HOST_RECALL_REQ) begin
          dir_rc_n    = 1'b1;
          from_host_n = 1'b1;
        end else if (HOST_STORE_REQ) begin
          dir_rc_n    = 1'b0;
          from_host_n = 1'b1;
        end else begin
          launch      = 1'b0;
        end
        if (launch) begin
          state_n = COPY;
          cnt_n   = '0;
        end
      end
      COPY: begin
        // Read address leads the write address by one cycle (1-cycle read latency).
        cnt_n = cnt_inc;
        if (cnt < CW'(DEPTH - 1)) begin
          raddr_n = cnt_inc[AW-1:0];
        end
        if (cnt < CW'(DEPTH)) begin
          waddr_n     = cnt[AW-1:0];
          ram_we_n    = dir_rc;
          shadow_we_n = ~dir_rc;
        end else begin
          state_n    = HOLD;
          hold_cnt_n = '0;
        end
      end
      HOLD: begin
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          state_n = IDLE;
          ack_n   = from_host;
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, edge-history and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      store_d   <= 1'b0;
      recalln_d <= 1'b1;
      pend_st   <= 1'b0;
      pend_rc   <= 1'b0;
      dir_rc    <= 1'b0;
      from_host <= 1'b0;
      cnt       <= '0;
      hold_cnt  <= '0;
      NV_RADDR  <= '0;
      NV_WADDR  <= '0;
      RAM_WE    <= 1'b0;
      SHADOW_WE <= 1'b0;
      HOST_ACK  <= 1'b0;
      NV_BUSY   <= 1'b0;
    end else begin
      state     <= state_n;
      store_d   <= STORE;
      recalln_d <= RECALLn;
      pend_st   <= pend_st_n;
      pend_rc   <= pend_rc_n;
      dir_rc    <= dir_rc_n;
      from_host <= from_host_n;
      cnt       <= cnt_n;
      hold_cnt  <= hold_cnt_n;
      NV_RADDR  <= raddr_n;
      NV_WADDR  <= waddr_n;
      RAM_WE    <= ram_we_n;
      SHADOW_WE <= shadow_we_n;
      HOST_ACK  <= ack_n;
      NV_BUSY   <= (state_n != IDLE);
    end
  end

  // Write data comes straight from the array read port so it lines up with the
  // registered write strobe; it is forced to zero whenever no strobe is active.
  assign WDATA = RAM_WE ? SHADOW_RDATA : (SHADOW_WE ? RAM_RDATA : '0);

endmodule

// File: tb/tb_nvram_sequencer.sv
// Bench for nvram_sequencer: behavioural arrays, per-operation reference model,
// directed scenarios followed by randomized strobe/host traffic.
module tb_nvram_sequencer;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 4;
  localparam int unsigned HOLD  = 16;
  localparam int          DEPTH = 256;
  localparam int          TOTAL = DEPTH + 1 + HOLD;

  logic          CLK, RESET, STORE, RECALLn, HSR, HRR;
  logic          HOST_ACK, NV_BUSY, RAM_WE, SHADOW_WE;
  logic [AW-1:0] NV_RADDR, NV_WADDR;
  logic [DW-1:0] ram_q, sh_q, WDATA;

  nvram_sequencer #(.AW(AW), .DW(DW), .HOLD_CYCLES(HOLD)) dut (
    .CLK(CLK), .RESET(RESET), .STORE(STORE), .RECALLn(RECALLn),
    .HOST_STORE_REQ(HSR), .HOST_RECALL_REQ(HRR), .HOST_ACK(HOST_ACK),
    .NV_BUSY(NV_BUSY), .NV_RADDR(NV_RADDR), .NV_WADDR(NV_WADDR),
    .RAM_RDATA(ram_q), .SHADOW_RDATA(sh_q), .RAM_WE(RAM_WE),
    .SHADOW_WE(SHADOW_WE), .WDATA(WDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Environment arrays (driven by DUT strobes) and reference arrays (model).
  logic [3:0] ram [DEPTH];
  logic [3:0] sh  [DEPTH];
  logic [3:0] ref_ram [DEPTH];
  logic [3:0] ref_sh  [DEPTH];

  // DUT outputs sampled mid-cycle, applied to the arrays on the next edge.
  logic [7:0] s_raddr, s_waddr;
  logic [3:0] s_wdata;
  logic       s_ramwe, s_shwe;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: op cycle index (-1 when idle), pending requests.
  int   m_j, m_wa;
  bit   m_dir, m_host, m_pst, m_prc, m_sd, m_rd, m_ack, m_wp, m_wdir;
  logic [3:0] m_wd;

  // Per-scenario observation counters.
  int t, c_busy, c_shwe, c_ramwe, c_ack, c_rise, first_ack, fall_t, rise2_t;
  bit prev_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_j = -1; m_dir = 0; m_host = 0; m_pst = 0; m_prc = 0;
    m_sd = 0; m_rd = 1; m_ack = 0; m_wp = 0; m_wa = 0; m_wd = '0; m_wdir = 0;
  endtask

  // One clock edge of the abstract operation model.
  task automatic model_update();
    bit st_e, rc_e, es, er;
    if (RESET) begin
      model_reset();
      return;
    end
    if (m_wp) begin
      if (m_wdir) ref_ram[m_wa] = m_wd;
      else        ref_sh[m_wa]  = m_wd;
    end
    m_wp = 0;
    st_e = STORE && !m_sd;
    rc_e = !RECALLn && m_rd;
    m_sd = STORE;
    m_rd = RECALLn;
    es = m_pst || (st_e && RECALLn);
    er = m_prc || rc_e;
    m_ack = 0;
    m_pst = es;
    m_prc = er;
    if (m_j < 0) begin
      if (er) begin
        m_j = 0; m_dir = 1; m_host = 0; m_prc = 0;
      end else if (es) begin
        m_j = 0; m_dir = 0; m_host = 0; m_pst = 0;
      end else if (HRR) begin
        m_j = 0; m_dir = 1; m_host = 1;
      end else if (HSR) begin
        m_j = 0; m_dir = 0; m_host = 1;
      end
    end else begin
      m_j++;
      if (m_j == TOTAL) begin
        m_j = -1;
        m_ack = m_host;
      end
    end
    if (m_j >= 1 && m_j <= DEPTH) begin
      m_wp = 1; m_wa = m_j - 1; m_wdir = m_dir;
      m_wd = m_dir ? ref_sh[m_wa] : ref_ram[m_wa];
    end
  endtask

  function automatic logic [31:0] exp_sig();
    logic [7:0] ra;
    ra = (m_j >= 0 && m_j < DEPTH) ? 8'(m_j) : 8'd0;
    return {8'd0, (m_j >= 0), m_ack, (m_wp && m_wdir), (m_wp && !m_wdir),
            ra, (m_wp ? 8'(m_wa) : 8'd0), (m_wp ? m_wd : 4'd0)};
  endfunction

  function automatic logic [31:0] dut_sig();
    return {8'd0, NV_BUSY, HOST_ACK, RAM_WE, SHADOW_WE, NV_RADDR, NV_WADDR, WDATA};
  endfunction

  task automatic sample();
    s_raddr = NV_RADDR; s_waddr = NV_WADDR; s_wdata = WDATA;
    s_ramwe = RAM_WE;   s_shwe  = SHADOW_WE;
  endtask

  task automatic clr();
    t = 0; c_busy = 0; c_shwe = 0; c_ramwe = 0; c_ack = 0; c_rise = 0;
    first_ack = 0; fall_t = 0; rise2_t = 0; prev_busy = NV_BUSY;
  endtask

  // Advance one cycle: arrays, model, then mid-cycle comparison of all outputs.
  task automatic tick();
    logic [3:0] rq, sq;
    @(posedge CLK);
    rq = ram[s_raddr];
    sq = sh[s_raddr];
    if (s_ramwe) ram[s_waddr] = s_wdata;
    if (s_shwe)  sh[s_waddr]  = s_wdata;
    ram_q = rq;
    sh_q  = sq;
    model_update();
    #1;
    sample();
    check("cycle", dut_sig(), exp_sig());
    t++;
    if (NV_BUSY) c_busy++;
    if (SHADOW_WE) c_shwe++;
    if (RAM_WE) c_ramwe++;
    if (HOST_ACK) begin
      c_ack++;
      if (first_ack == 0) first_ack = t;
    end
    if (NV_BUSY && !prev_busy) begin
      c_rise++;
      if (c_rise == 2) rise2_t = t;
    end
    if (!NV_BUSY && prev_busy && fall_t == 0) fall_t = t;
    prev_busy = NV_BUSY;
    if (m_ack) begin
      if (m_dir) HRR = 1'b0;
      else       HSR = 1'b0;
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((m_j >= 0 || m_pst || m_prc || HRR || HSR || NV_BUSY) && n < limit) begin
      tick();
      n++;
    end
    check("wait_timeout", 32'(n >= limit), 32'd0);
  endtask

  task automatic cmp_arrays(input string tag);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ram[i] !== ref_ram[i]) bad++;
      if (sh[i]  !== ref_sh[i])  bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int n, bad;
    RESET = 1'b1; STORE = 1'b0; RECALLn = 1'b1; HSR = 1'b0; HRR = 1'b0;
    ram_q = '0; sh_q = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0; sh[i] = '0; ref_ram[i] = '0; ref_sh[i] = '0;
    end
    s_raddr = '0; s_waddr = '0; s_wdata = '0; s_ramwe = 0; s_shwe = 0;
    model_reset();
    repeat (3) tick();
    check("reset_outs", dut_sig(), 32'd0);
    RESET = 1'b0;
    tick();
    check("idle_busy", 32'(NV_BUSY), 32'd0);

    // Store with RAM preloaded as address[3:0].
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = 4'(i); ref_ram[i] = 4'(i);
    end
    clr();
    STORE = 1'b1;
    tick();
    check("st_latency", 32'(NV_BUSY), 32'd1);
    STORE = 1'b0;
    wait_idle(400);
    check("st_we_cycles", 32'(c_shwe), 32'd256);
    check("st_busy_cycles", 32'(c_busy), 32'd273);
    check("st_no_ack", 32'(c_ack), 32'd0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (sh[i] !== 4'(i)) bad++;
    check("st_shadow", 32'(bad), 32'd0);

    // Recall with shadow preloaded to 0xA.
    for (int i = 0; i < DEPTH; i++) begin
      sh[i] = 4'hA; ref_sh[i] = 4'hA;
    end
    clr();
    RECALLn = 1'b0;
    repeat (4) tick();
    RECALLn = 1'b1;
    wait_idle(400);
    check("rc_we_cycles", 32'(c_ramwe), 32'd256);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== 4'hA) bad++;
    check("rc_ram_a", 32'(bad), 32'd0);

    // Store edge coinciding with recall: store is inhibited.
    for (int i = 0; i < DEPTH; i++) begin
      sh[i] = 4'($urandom); ref_sh[i] = sh[i];
    end
    clr();
    STORE = 1'b1; RECALLn = 1'b0;
    repeat (6) tick();
    STORE = 1'b0;
    tick();
    RECALLn = 1'b1;
    wait_idle(400);
    check("inh_shwe", 32'(c_shwe), 32'd0);
    check("inh_ramwe", 32'(c_ramwe), 32'd256);
    check("inh_ops", 32'(c_rise), 32'd1);

    // Both host requests: recall first, then store, one ack each.
    clr();
    HRR = 1'b1; HSR = 1'b1;
    wait_idle(800);
    check("host_acks", 32'(c_ack), 32'd2);
    check("host_ack_t", 32'(first_ack), 32'd274);
    check("host_ops", 32'(c_rise), 32'd2);
    check("host_we", 32'({c_ramwe[15:0], c_shwe[15:0]}), {16'd256, 16'd256});

    // Two store pulses during a recall merge into one store.
    clr();
    RECALLn = 1'b0;
    tick();
    RECALLn = 1'b1;
    repeat (10) tick();
    STORE = 1'b1; tick(); STORE = 1'b0;
    repeat (20) tick();
    STORE = 1'b1; tick(); STORE = 1'b0;
    wait_idle(800);
    check("merge_ops", 32'(c_rise), 32'd2);
    check("merge_shwe", 32'(c_shwe), 32'd256);
    check("merge_busy", 32'(c_busy), 32'd546);
    check("merge_gap", 32'(rise2_t - fall_t), 32'd1);
    cmp_arrays("arrays_directed");

    // Reset during a copy at address 100.
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = 4'($urandom); ref_ram[i] = ram[i];
    end
    clr();
    STORE = 1'b1; tick(); STORE = 1'b0;
    n = 0;
    while (m_j != 100 && n < 200) begin tick(); n++; end
    check("rst_reach", 32'(NV_RADDR), 32'd100);
    #2 RESET = 1'b1;
    #1 sample();
    check("rst_async", dut_sig(), 32'd0);
    model_reset();
    repeat (2) tick();
    RESET = 1'b0;
    tick();
    check("post_rst", {30'd0, NV_BUSY, HOST_ACK}, 32'd0);
    clr();
    STORE = 1'b1; tick(); STORE = 1'b0;
    check("restart_addr", {23'd0, NV_BUSY, NV_RADDR}, {23'd0, 1'b1, 8'd0});
    wait_idle(400);
    cmp_arrays("arrays_after_reset");

    // Randomized CPU strobes and host requests.
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = 4'($urandom); ref_ram[i] = ram[i];
      sh[i]  = 4'($urandom); ref_sh[i]  = sh[i];
    end
    repeat (14) begin
      case ($urandom_range(0, 4))
        0: begin STORE = 1'b1; repeat ($urandom_range(1, 3)) tick(); STORE = 1'b0; end
        1: begin RECALLn = 1'b0; repeat ($urandom_range(1, 4)) tick(); RECALLn = 1'b1; end
        2: HRR = 1'b1;
        3: HSR = 1'b1;
        default: begin HRR = 1'b1; HSR = 1'b1; end
      endcase
      repeat ($urandom_range(0, 320)) tick();
    end
    wait_idle(3000);
    cmp_arrays("arrays_random");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/nvram_sequencer.md
Name: nvram_sequencer

Overview:
- Sequences the non-volatile high-score RAM (X2212-style NOVRAM model) from the STORE and RECALLn strobes of the output latch.
- Copies the working RAM array into the shadow (non-volatile) array on STORE and the reverse on RECALL.
- Arbitrates CPU-initiated operations against host (MiSTer save/load) requests.
- Holds NV_BUSY so the CPU-side NVRAM access path is stalled during a copy.

Parameters:
- AW, 8, address width; array depth is 2^AW nibbles.
- DW, 4, data width of both arrays.
- HOLD_CYCLES, 16, minimum busy cycles after a copy completes (store/recall settle time); legal range 1..65535.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- STORE  in  1  level from output latch; a rising edge requests a store.
- RECALLn  in  1  level from output latch; a falling edge requests a recall.
- HOST_STORE_REQ  in  1  level; held high until HOST_ACK.
- HOST_RECALL_REQ  in  1  level; held high until HOST_ACK.
- HOST_ACK  out  1  one-cycle pulse when a host-initiated operation finishes.
- NV_BUSY  out  1  high whenever state is not IDLE.
- NV_RADDR  out  AW  read address presented to both arrays (synchronous read, 1-cycle latency).
- NV_WADDR  out  AW  write address to both arrays.
- RAM_RDATA  in  DW  working RAM read data.
- SHADOW_RDATA  in  DW  shadow array read data.
- RAM_WE  out  1  working RAM write strobe (recall).
- SHADOW_WE  out  1  shadow array write strobe (store).
- WDATA  out  DW  write data for either array.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - store_d=0, recalln_d=1; pending flags 0; address and hold counters 0.
  - Reset mid-operation aborts immediately; no HOST_ACK; a partially written array is left as-is.
- Edge detection, registered every cycle:
  - st_edge = STORE & ~store_d.
  - rc_edge = ~RECALLn & recalln_d.
- Pending flags:
  - st_edge sets pend_st, but only if RECALLn=1 (a store is inhibited while recall is asserted).
  - rc_edge sets pend_rc.
  - Flags capture edges in any state; each flag holds at most one request, so further edges while set are merged.
  - A flag clears on the edge where its operation is launched.
- IDLE arbitration, evaluated each cycle in fixed priority: pend_rc > pend_st > HOST_RECALL_REQ > HOST_STORE_REQ.
  - The winner loads the direction (rc/st) and an origin bit (cpu/host), resets the address counter to 0, and moves to COPY on the next edge.
  - An edge detected in the same cycle is arbitrated directly, giving 1-cycle latency from the input edge to NV_BUSY=1.
- COPY (pipelined):
  - Cycle k, for k = 0..2^AW-1: NV_RADDR=k.
  - Cycle k+1: NV_WADDR=k; WDATA = SHADOW_RDATA for recall or RAM_RDATA for store; RAM_WE (recall) or SHADOW_WE (store) =1.
  - The write strobe is asserted for exactly 2^AW cycles, starting on the 2nd COPY cycle.
  - COPY lasts 2^AW+1 cycles.
  - The address counter does not wrap: after 2^AW-1 it stops issuing reads, and the last write completes the state.
- HOLD:
  - The hold counter counts HOLD_CYCLES cycles with no strobes, then the state returns to IDLE.
  - On the HOLD->IDLE edge, HOST_ACK pulses for 1 cycle if origin=host.
  - A host request still high in the IDLE cycle after HOST_ACK is treated as a new request; the host must drop it on HOST_ACK.
- Busy period: NV_BUSY=1 for exactly 2^AW+1+HOLD_CYCLES cycles per operation.
- Simultaneous events:
  - Simultaneous rc_edge and st_edge: the store is inhibited (RECALLn=0), so only recall runs.
  - An st_edge during a recall-in-progress with RECALLn already back high is kept pending and runs after the recall.
  - Host requests are never queued; they are only sampled in IDLE.

Test Plan:
- Reset, then STORE 0->1 with RAM preloaded as addr[3:0]: NV_BUSY rises 1 cycle later; SHADOW_WE high for 256 cycles with WDATA=NV_WADDR[3:0]; NV_BUSY high for 273 cycles; no HOST_ACK.
- RECALLn 1->0 with shadow preloaded 0xA: RAM_WE for 256 cycles, WDATA=0xA at every address; RAM fully equals 0xA afterwards.
- STORE rising while RECALLn=0: no store ever runs; only the recall executes (SHADOW_WE stays 0 throughout).
- HOST_RECALL_REQ and HOST_STORE_REQ both high in IDLE: recall runs first; HOST_ACK pulses once at the end (cycle 274); the host drops RECALL_REQ; store then runs and acks.
- STORE edge pulsed twice during an active recall: exactly one store follows the recall (merged pending), with back-to-back NV_BUSY and a single IDLE gap cycle.
- Assert RESET at COPY address 100: all outputs 0 asynchronously; after release, IDLE with NV_BUSY=0 and no HOST_ACK; a fresh STORE edge restarts the copy from address 0.
